// File: rtl/multi_dataflow_out_tracker_pkg.sv
// Shared types for the multi_dataflow output tracker: FSM state encoding
// and the control/flag groupings used between the tracker and the controller.
package multi_dataflow_package;

    localparam int unsigned OUT_TRACKER_CNT_WIDTH = 32;
    localparam int unsigned OUT_TRACKER_DIM_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } out_tracker_state_t;

    typedef struct packed {
        logic [OUT_TRACKER_CNT_WIDTH-1:0] limit;
        logic [OUT_TRACKER_DIM_WIDTH-1:0] width;
        logic [OUT_TRACKER_DIM_WIDTH-1:0] height;
    } ctrl_out_tracker_t;

    typedef struct packed {
        logic                             busy;
        logic                             done;
        logic                             err;
        logic [OUT_TRACKER_CNT_WIDTH-1:0] cnt;
        logic [OUT_TRACKER_DIM_WIDTH-1:0] x;
        logic [OUT_TRACKER_DIM_WIDTH-1:0] y;
    } flags_out_tracker_t;

endpackage

// File: rtl/multi_dataflow_out_tracker_elastic_reg.sv
// One-entry valid/ready register carrying data, strobe and a last flag.
// Upstream may load whenever the slot is empty or is being drained this cycle.
module multi_dataflow_elastic_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_last_o
);

    logic                    full_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic                    last_q;

    assign in_ready_o  = !full_q || out_ready_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign out_strb_o  = strb_q;
    assign out_last_o  = last_q;

    // Load on accept (a simultaneous pop keeps the slot full), otherwise empty on pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            full_q <= 1'b1;
            data_q <= in_data_i;
            strb_q <= in_strb_i;
            last_q <= in_last_i;
        end else if (out_ready_i) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_dataflow_out_tracker.sv
// Output-side tracker for the multi_dataflow HWPE: forwards engine beats through
// an elastic register, counts them against the job limit, tracks the (x, y)
// pixel coordinate, tags the final beat and reports done / protocol errors.
module multi_dataflow_out_tracker
    import multi_dataflow_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    cnt_limit_i,
    input  logic [DIM_WIDTH-1:0]    width_i,
    input  logic [DIM_WIDTH-1:0]    height_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [CNT_WIDTH-1:0]    cnt_o,
    output logic [DIM_WIDTH-1:0]    x_o,
    output logic [DIM_WIDTH-1:0]    y_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    out_tracker_state_t   state_q;
    logic [CNT_WIDTH-1:0] limit_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [DIM_WIDTH-1:0] width_q;
    logic [DIM_WIDTH-1:0] height_q;
    logic [DIM_WIDTH-1:0] x_q;
    logic [DIM_WIDTH-1:0] y_q;
    logic                 err_q;

    logic reg_in_ready;
    logic accept;
    logic pop;
    logic last_beat;
    logic x_wrap;
    logic y_wrap;
    logic proto_err;

    // A zero width/height wraps naturally: 0 - 1 is all ones, i.e. 2^DIM_WIDTH beats
    assign last_beat = (cnt_q == limit_q - CNT_ONE);
    assign x_wrap    = (x_q == width_q - DIM_ONE);
    assign y_wrap    = (y_q == height_q - DIM_ONE);

    assign in_ready_o = (state_q == RUN) && (limit_q != '0) && reg_in_ready;
    assign accept     = in_valid_i && in_ready_o;
    assign pop        = out_valid_o && out_ready_i;
    assign proto_err  = (start_i && (state_q != IDLE)) || (in_valid_i && (state_q != RUN));

    assign busy_o = (state_q == RUN) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;
    assign cnt_o  = cnt_q;
    assign x_o    = x_q;
    assign y_o    = y_q;

    multi_dataflow_elastic_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) i_elastic_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (accept),
        .in_ready_o  (reg_in_ready),
        .in_data_i   (in_data_i),
        .in_strb_i   (in_strb_i),
        .in_last_i   (last_beat),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_last_o  (out_last_o)
    );

    // Job FSM with beat counter, coordinate tracking and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            if (proto_err) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        limit_q  <= cnt_limit_i;
                        width_q  <= width_i;
                        height_q <= height_i;
                        cnt_q    <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        err_q    <= proto_err;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (limit_q == '0) begin
                        state_q <= DONE;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (x_wrap) begin
                            x_q <= '0;
                            y_q <= y_wrap ? '0 : y_q + DIM_ONE;
                        end else begin
                            x_q <= x_q + DIM_ONE;
                        end
                        if (last_beat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_o || pop) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dataflow_out_tracker.sv
// Self-checking bench for multi_dataflow_out_tracker: directed scenarios plus
// randomized jobs checked against a beat-list / modulo-arithmetic reference.
module tb_multi_dataflow_out_tracker;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [31:0] cnt_limit_i;
    logic [15:0] width_i;
    logic [15:0] height_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic [3:0]  in_strb_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] cnt_o;
    logic [15:0] x_o;
    logic [15:0] y_o;

    int n_checks = 0;
    int n_fail   = 0;

    multi_dataflow_out_tracker #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (32),
        .DIM_WIDTH  (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .cnt_limit_i (cnt_limit_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_strb_i   (in_strb_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .cnt_o       (cnt_o),
        .x_o         (x_o),
        .y_o         (y_o)
    );

    // 10 time-unit clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Check that every output sits at its reset value
    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({in_ready_o, out_valid_o, out_last_o, busy_o, done_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL %s flags: got %b expected 000000", tag,
                     {in_ready_o, out_valid_o, out_last_o, busy_o, done_o, err_o});
        end
        n_checks++;
        if ({cnt_o, x_o, y_o, out_data_o, out_strb_o} !== 100'b0) begin
            n_fail++;
            $display("[TB] FAIL %s values: cnt=%0d x=%0d y=%0d data=%h strb=%h expected all 0",
                     tag, cnt_o, x_o, y_o, out_data_o, out_strb_o);
        end
    endtask

    // Run one job; the model is the list of beats plus accepted/popped counts.
    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // extra_start: loop cycle at which a stray start_i is issued (-1 = none).
    task automatic run_job(input string tag, input int limit, input int w, input int h,
                           input int ready_mode, input int extra_start);
        logic [31:0] beat_data[$];
        logic [3:0]  beat_strb[$];
        int ww, hh, acc, popd, cyc, occ;
        bit done_due, done_seen, last_pop, exp_err, exp_ready;
        ww = (w == 0) ? 65536 : w;
        hh = (h == 0) ? 65536 : h;
        for (int i = 0; i < limit; i++) begin
            beat_data.push_back($urandom);
            beat_strb.push_back(4'($urandom));
        end
        @(negedge clk_i);
        start_i     = 1'b1;
        cnt_limit_i = limit;
        width_i     = 16'(w);
        height_i    = 16'(h);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
        acc       = 0;
        popd      = 0;
        cyc       = 0;
        done_due  = 1'b0;
        done_seen = 1'b0;
        exp_err   = 1'b0;
        while (!done_seen && cyc < limit * 8 + 20) begin
            in_valid_i = (acc < limit);
            in_data_i  = (acc < limit) ? beat_data[acc] : 32'h0;
            in_strb_i  = (acc < limit) ? beat_strb[acc] : 4'h0;
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (cyc == extra_start) begin
                start_i     = 1'b1;
                cnt_limit_i = 1;
            end else begin
                start_i     = 1'b0;
                cnt_limit_i = limit;
            end
            #1;
            occ       = acc - popd;
            exp_ready = (acc < limit) && (occ == 0 || out_ready_i);
            n_checks++;
            if (in_ready_o !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL %s in_ready cyc=%0d: got %b expected %b", tag, cyc, in_ready_o, exp_ready);
            end
            n_checks++;
            if (out_valid_o !== (occ == 1)) begin
                n_fail++;
                $display("[TB] FAIL %s out_valid cyc=%0d: got %b expected %b", tag, cyc, out_valid_o, occ == 1);
            end
            n_checks++;
            if (done_o !== done_due || busy_o !== !done_due) begin
                n_fail++;
                $display("[TB] FAIL %s done/busy cyc=%0d: got %b/%b expected %b/%b", tag, cyc,
                         done_o, busy_o, done_due, !done_due);
            end
            n_checks++;
            if (err_o !== exp_err) begin
                n_fail++;
                $display("[TB] FAIL %s err cyc=%0d: got %b expected %b", tag, cyc, err_o, exp_err);
            end
            if (done_o === 1'b1) begin
                done_seen = 1'b1;
            end
            last_pop = 1'b0;
            if (out_valid_o === 1'b1 && popd < limit) begin
                n_checks++;
                if (out_data_o !== beat_data[popd] || out_strb_o !== beat_strb[popd]
                    || out_last_o !== (popd == limit - 1)) begin
                    n_fail++;
                    $display("[TB] FAIL %s beat %0d: got %h/%h/%b expected %h/%h/%b", tag, popd,
                             out_data_o, out_strb_o, out_last_o, beat_data[popd], beat_strb[popd],
                             popd == limit - 1);
                end
                if (out_ready_i) begin
                    popd++;
                    last_pop = (popd == limit);
                end
            end
            if (in_valid_i && in_ready_o === 1'b1) begin
                n_checks++;
                if (cnt_o !== acc || x_o !== 16'(acc % ww) || y_o !== 16'((acc / ww) % hh)) begin
                    n_fail++;
                    $display("[TB] FAIL %s accept %0d: got cnt=%0d x=%0d y=%0d expected %0d %0d %0d", tag,
                             acc, cnt_o, x_o, y_o, acc, acc % ww, (acc / ww) % hh);
                end
                acc++;
            end
            if (cyc == extra_start) begin
                exp_err = 1'b1;
            end
            done_due = last_pop;
            @(negedge clk_i);
            cyc++;
        end
        start_i     = 1'b0;
        cnt_limit_i = limit;
        in_valid_i  = 1'b0;
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("[TB] FAIL %s timeout: done seen %b expected 1 (accepted %0d popped %0d)", tag,
                     done_seen, acc, popd);
        end
        #1;
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0 || cnt_o !== limit
            || x_o !== 16'(limit % ww) || y_o !== 16'((limit / ww) % hh)) begin
            n_fail++;
            $display("[TB] FAIL %s after job: done=%b busy=%b rdy=%b cnt=%0d x=%0d y=%0d expected 0 0 0 %0d %0d %0d",
                     tag, done_o, busy_o, in_ready_o, cnt_o, x_o, y_o, limit, limit % ww, (limit / ww) % hh);
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        cnt_limit_i = '0;
        width_i     = '0;
        height_i    = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_strb_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check_reset_values("post_reset");
    endtask

    task automatic test_basic();
        run_job("basic", 6, 3, 2, 0, -1);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 4, 2, 2, 1, -1);
    endtask

    task automatic test_zero_limit();
        @(negedge clk_i);
        start_i     = 1'b1;
        cnt_limit_i = 0;
        width_i     = 16'd4;
        height_i    = 16'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_limit cycle1: rdy=%b done=%b expected 0 0", in_ready_o, done_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (in_ready_o !== 1'b0 || done_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_limit cycle2: rdy=%b done=%b expected 0 1", in_ready_o, done_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || cnt_o !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_limit cycle3: done=%b busy=%b cnt=%0d expected 0 0 0", done_o, busy_o, cnt_o);
        end
    endtask

    task automatic test_protocol_errors();
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_valid ready: got %b expected 0", in_ready_o);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        n_checks++;
        if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_valid err: err=%b out_valid=%b expected 1 0", err_o, out_valid_o);
        end
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_sticky: got %b expected 1", err_o);
        end
        run_job("restart_in_run", 5, 4, 3, 0, 1);
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_after_job: got %b expected 1", err_o);
        end
        run_job("err_cleared", 3, 2, 2, 0, -1);
    endtask

    task automatic test_clear();
        int acc;
        @(negedge clk_i);
        start_i     = 1'b1;
        cnt_limit_i = 8;
        width_i     = 16'd4;
        height_i    = 16'd4;
        @(negedge clk_i);
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        acc         = 0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = $urandom;
            in_strb_i  = 4'hF;
            clear_i    = (acc == 2);
            #1;
            if (in_ready_o === 1'b1) acc++;
            @(negedge clk_i);
        end
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || cnt_o !== 0 || done_o !== 1'b0
            || x_o !== 0 || y_o !== 0 || acc !== 3) begin
            n_fail++;
            $display("[TB] FAIL clear: valid=%b busy=%b cnt=%0d done=%b x=%0d y=%0d acc=%0d expected 0 0 0 0 0 0 3",
                     out_valid_o, busy_o, cnt_o, done_o, x_o, y_o, acc);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1;
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL clear_quiet cyc=%0d: done=%b busy=%b expected 0 0", c, done_o, busy_o);
            end
        end
        run_job("after_clear", 2, 3, 3, 0, -1);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            run_job("random", $urandom_range(1, 12), $urandom_range(1, 5), $urandom_range(1, 4),
                    $urandom_range(0, 2), -1);
        end
        run_job("wide_zero_dims", 5, 0, 0, 2, -1);
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        start_i     = 1'b1;
        cnt_limit_i = 2;
        width_i     = 16'd2;
        height_i    = 16'd2;
        @(negedge clk_i);
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h1111_2222;
        in_strb_i   = 4'h3;
        @(negedge clk_i);
        in_data_i   = 32'h3333_4444;
        in_strb_i   = 4'hC;
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b1 || out_valid_o !== 1'b1 || out_last_o !== 1'b1 || out_data_o !== 32'h3333_4444) begin
            n_fail++;
            $display("[TB] FAIL drain_setup: busy=%b valid=%b last=%b data=%h expected 1 1 1 33334444",
                     busy_o, out_valid_o, out_last_o, out_data_o);
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL post_async cyc=%0d: done=%b busy=%b expected 0 0", c, done_o, busy_o);
            end
        end
        run_job("after_async", 3, 2, 2, 0, -1);
    endtask

    // Run the scenarios in sequence and report
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_limit();
        test_protocol_errors();
        test_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
